// File: rtl/lc_1252_job_arbiter.sv
// Round-robin job arbiter for the odd-matrix engine; result appears 1 cycle after eng_out_tvalid, held until res_tready.
// Index beats pass through combinationally under eng_tready; optional result-wait timeout via LC1252_ARB_TIMEOUT_EN.
module lc_1252_job_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int MAX_IND_LEN = 100,
  parameter int TIMEOUT_CYC = 1024,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0][7:0]         req_m,
  input  logic [NUM_REQ-1:0][7:0]         req_n,
  input  logic [NUM_REQ-1:0][1:0][7:0]    req_tdata,
  input  logic [NUM_REQ-1:0]              req_tvalid,
  input  logic [NUM_REQ-1:0]              req_tlast,
  output logic [NUM_REQ-1:0]              req_tready,
  output logic [7:0]                      eng_m,
  output logic [7:0]                      eng_n,
  output logic [1:0][7:0]                 eng_tdata,
  output logic                            eng_tvalid,
  output logic                            eng_tlast,
  input  logic                            eng_tready,
  output logic                            eng_rst,
  input  logic [7:0]                      eng_odd_cells,
  input  logic                            eng_out_tvalid,
  output logic [7:0]                      res_odd_cells,
  output logic [ID_W-1:0]                 res_id,
  output logic                            res_err,
  output logic                            res_tvalid,
  input  logic                            res_tready
);

  localparam int CNT_W = $clog2(MAX_IND_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_IND_LEN - 1);

  typedef enum logic [2:0] {CLEAN, IDLE, STREAM, DRAIN, WAIT_RES, RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last_grant, grant_id, pick;
  logic              pick_vld;
  logic [CNT_W-1:0]  beat_cnt;
  logic              err;
  logic              at_cap;
  logic              stream_hs;
  logic              tmo_hit;

  assign at_cap    = (beat_cnt == LAST_BEAT);
  assign stream_hs = (state == STREAM) && req_tvalid[grant_id] && eng_tready;

  assign eng_rst    = (state == CLEAN);
  assign res_tvalid = (state == RESP);
  assign res_id     = grant_id;
  assign res_err    = err;

`ifdef LC1252_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tmo_cnt <= '0;
    else if (state == WAIT_RES) tmo_cnt <= tmo_cnt + 16'd1;
    else                       tmo_cnt <= '0;
  end

  assign tmo_hit = (state == WAIT_RES) && !eng_out_tvalid && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    pick     = last_grant;
    pick_vld = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_vld && req_tvalid[ID_W'((int'(last_grant) + i) % NUM_REQ)]) begin
        pick     = ID_W'((int'(last_grant) + i) % NUM_REQ);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    eng_tvalid = 1'b0;
    eng_tdata  = '0;
    eng_tlast  = 1'b0;
    req_tready = '0;
    case (state)
      CLEAN: state_nxt = IDLE;
      IDLE:  if (pick_vld) state_nxt = STREAM;
      STREAM: begin
        eng_tvalid           = req_tvalid[grant_id];
        eng_tdata            = req_tdata[grant_id];
        eng_tlast            = req_tlast[grant_id] | at_cap;
        req_tready[grant_id] = eng_tready;
        if (stream_hs) begin
          if (req_tlast[grant_id]) state_nxt = WAIT_RES;
          else if (at_cap)         state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        req_tready[grant_id] = 1'b1;
        if (req_tvalid[grant_id] && req_tlast[grant_id]) state_nxt = WAIT_RES;
      end
      WAIT_RES: if (eng_out_tvalid || tmo_hit) state_nxt = RESP;
      RESP:     if (res_tready) state_nxt = CLEAN;
      default:  state_nxt = CLEAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant    <= ID_W'(NUM_REQ - 1);
      grant_id      <= '0;
      eng_m         <= '0;
      eng_n         <= '0;
      beat_cnt      <= '0;
      err           <= 1'b0;
      res_odd_cells <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          grant_id   <= pick;
          last_grant <= pick;
          eng_m      <= req_m[pick];
          eng_n      <= req_n[pick];
          beat_cnt   <= '0;
          err        <= 1'b0;
        end
        STREAM: if (stream_hs) begin
          beat_cnt <= beat_cnt + CNT_W'(1);
          if (at_cap && !req_tlast[grant_id]) err <= 1'b1;
        end
        WAIT_RES: begin
          if (eng_out_tvalid) begin
            res_odd_cells <= eng_odd_cells;
          end else if (tmo_hit) begin
            res_odd_cells <= '0;
            err           <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc_1252_job_arbiter.sv
// Directed bench for lc_1252_job_arbiter: two requesters, MAX_IND_LEN=4, TIMEOUT_CYC=8.
module tb_lc_1252_job_arbiter;

  logic                  clk;
  logic                  rst_n;
  logic [1:0][7:0]       req_m, req_n;
  logic [1:0][1:0][7:0]  req_tdata;
  logic [1:0]            req_tvalid, req_tlast, req_tready;
  logic [7:0]            eng_m, eng_n;
  logic [1:0][7:0]       eng_tdata;
  logic                  eng_tvalid, eng_tlast, eng_tready, eng_rst;
  logic [7:0]            eng_odd_cells;
  logic                  eng_out_tvalid;
  logic [7:0]            res_odd_cells;
  logic [0:0]            res_id;
  logic                  res_err, res_tvalid, res_tready;

  int errors = 0;
  int checks = 0;
  int seen, last_at, drained;

  lc_1252_job_arbiter #(.NUM_REQ(2), .MAX_IND_LEN(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_m(req_m), .req_n(req_n),
    .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tlast(req_tlast), .req_tready(req_tready),
    .eng_m(eng_m), .eng_n(eng_n),
    .eng_tdata(eng_tdata), .eng_tvalid(eng_tvalid), .eng_tlast(eng_tlast), .eng_tready(eng_tready),
    .eng_rst(eng_rst), .eng_odd_cells(eng_odd_cells), .eng_out_tvalid(eng_out_tvalid),
    .res_odd_cells(res_odd_cells), .res_id(res_id), .res_err(res_err),
    .res_tvalid(res_tvalid), .res_tready(res_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Streams nb beats (row=b, col=b+1) from requester id, tlast on the last one.
  task automatic send_beats(input int id, input int nb, output int n_seen, output int n_last, output int n_drain);
    int t;
    n_seen = 0; n_last = 0; n_drain = 0;
    for (int b = 0; b < nb; b++) begin
      req_tdata[id]  = {8'(b + 1), 8'(b)};
      req_tlast[id]  = (b == nb - 1);
      req_tvalid[id] = 1'b1;
      #1;
      t = 0;
      while (!req_tready[id] && t < 20) begin
        tick();
        t++;
      end
      check("grant_wait", 32'(t < 20), 32'd1);
      check("ready_onehot", 32'(req_tready), 32'(2'b01 << id));
      if (eng_tvalid) begin
        n_seen++;
        if (eng_tlast) n_last = n_seen;
      end else begin
        n_drain++;
      end
      tick();
    end
    req_tvalid[id] = 1'b0;
    req_tlast[id]  = 1'b0;
  endtask

  task automatic respond(input string tag, input logic [7:0] odd, input int id, input logic err);
    eng_odd_cells  = odd;
    eng_out_tvalid = 1'b1;
    tick();
    eng_out_tvalid = 1'b0;
    eng_odd_cells  = 8'hEE;
    #1;
    check({tag, "_vld"}, 32'(res_tvalid), 32'd1);
    check({tag, "_odd"}, 32'(res_odd_cells), 32'(odd));
    check({tag, "_id"},  32'(res_id), 32'(id));
    check({tag, "_err"}, 32'(res_err), 32'(err));
  endtask

  task automatic release_res();
    res_tready = 1'b1;
    tick();
    res_tready = 1'b0;
    check("rel_vld_low", 32'(res_tvalid), 32'd0);
    check("rel_eng_rst", 32'(eng_rst), 32'd1);
    tick();
    check("rel_eng_rst_one", 32'(eng_rst), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_m = '0; req_n = '0; req_tdata = '0; req_tvalid = '0; req_tlast = '0;
    eng_tready = 1'b1; eng_odd_cells = '0; eng_out_tvalid = 1'b0; res_tready = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_eng_rst", 32'(eng_rst), 32'd1);
    check("rst_req_tready", 32'(req_tready), 32'd0);
    check("rst_eng_tvalid", 32'(eng_tvalid), 32'd0);
    check("rst_eng_tlast", 32'(eng_tlast), 32'd0);
    check("rst_eng_m", 32'(eng_m), 32'd0);
    check("rst_eng_n", 32'(eng_n), 32'd0);
    check("rst_res_vld", 32'(res_tvalid), 32'd0);
    check("rst_res_odd", 32'(res_odd_cells), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);

    rst_n = 1'b1;
    #1;
    check("clean_after_rst", 32'(eng_rst), 32'd1);

    // Requester 0: m=2 n=3, beats (0,1),(1,1) -> 6 odd cells
    req_m[0] = 8'd2; req_n[0] = 8'd3;
    req_tdata[0] = {8'd1, 8'd0};
    req_tvalid[0] = 1'b1;
    tick();
    check("clean_one_cycle", 32'(eng_rst), 32'd0);
    check("idle_no_ready", 32'(req_tready), 32'd0);
    tick();
    check("j0_eng_m", 32'(eng_m), 32'd2);
    check("j0_eng_n", 32'(eng_n), 32'd3);
    check("j0_eng_tvalid", 32'(eng_tvalid), 32'd1);
    check("j0_req_tready", 32'(req_tready), 32'b01);
    check("j0_tdata0", 32'(eng_tdata), 32'h0100);
    check("j0_tlast0", 32'(eng_tlast), 32'd0);
    tick();
    req_tdata[0] = {8'd1, 8'd1};
    req_tlast[0] = 1'b1;
    #1;
    check("j0_tdata1", 32'(eng_tdata), 32'h0101);
    check("j0_tlast1", 32'(eng_tlast), 32'd1);
    tick();
    req_tvalid[0] = 1'b0;
    req_tlast[0]  = 1'b0;
    #1;
    check("wait_eng_tvalid", 32'(eng_tvalid), 32'd0);
    check("wait_req_tready", 32'(req_tready), 32'd0);
    check("wait_res_vld", 32'(res_tvalid), 32'd0);
    tick();
    check("wait_res_vld2", 32'(res_tvalid), 32'd0);
    respond("j0", 8'd6, 0, 1'b0);
    release_res();

    // Requester 1: m=2 n=2, beats (1,1),(0,0) -> 0; drops tvalid mid-job
    req_m[1] = 8'd2; req_n[1] = 8'd2;
    req_tdata[1] = {8'd1, 8'd1};
    req_tvalid[1] = 1'b1;
    tick();
    check("j1_req_tready", 32'(req_tready), 32'b10);
    check("j1_eng_m", 32'(eng_m), 32'd2);
    tick();
    req_tvalid[1] = 1'b0;
    req_tdata[1]  = {8'd0, 8'd0};
    req_m[0] = 8'd9;
    req_tvalid[0] = 1'b1;
    tick();
    tick();
    check("drop_keeps_grant", 32'(req_tready), 32'b10);
    check("drop_eng_tvalid", 32'(eng_tvalid), 32'd0);
    check("drop_eng_m", 32'(eng_m), 32'd2);
    req_tvalid[0] = 1'b0;
    req_tvalid[1] = 1'b1;
    req_tlast[1]  = 1'b1;
    #1;
    check("j1_tlast", 32'(eng_tlast), 32'd1);
    tick();
    req_tvalid[1] = 1'b0;
    req_tlast[1]  = 1'b0;
    respond("j1", 8'd0, 1, 1'b0);

    // Result backpressure with another requester waiting
    req_tvalid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_vld", 32'(res_tvalid), 32'd1);
      check("stall_id", 32'(res_id), 32'd1);
      check("stall_no_grant", 32'(req_tready), 32'd0);
    end
    req_tvalid[0] = 1'b0;
    release_res();

    // Tie rotation: 1x3 matrices, single beat (0,1) -> 2 odd cells
    req_m = {8'd1, 8'd1}; req_n = {8'd3, 8'd3};
    req_tdata[1] = {8'd1, 8'd0};
    req_tvalid[1] = 1'b1; req_tlast[1] = 1'b1;
    send_beats(0, 1, seen, last_at, drained);
    check("tie1_beats", 32'(seen), 32'd1);
    respond("tie1", 8'd2, 0, 1'b0);
    release_res();
    send_beats(1, 1, seen, last_at, drained);
    respond("tie1_next", 8'd2, 1, 1'b0);
    release_res();
    req_tvalid[1] = 1'b1; req_tlast[1] = 1'b1;
    send_beats(0, 1, seen, last_at, drained);
    respond("tie2", 8'd2, 0, 1'b0);
    release_res();
    req_tvalid[1] = 1'b0; req_tlast[1] = 1'b0;

    // Overlong job: 6 beats into 8x8, engine sees 4 -> 32 odd cells, err set
    req_m[0] = 8'd8; req_n[0] = 8'd8;
    send_beats(0, 6, seen, last_at, drained);
    check("cap_seen", 32'(seen), 32'd4);
    check("cap_last_at", 32'(last_at), 32'd4);
    check("cap_drained", 32'(drained), 32'd2);
    respond("cap", 8'd32, 0, 1'b1);
    release_res();

    // Reset mid-job aborts without a result; rotation pointer restored
    req_m[0] = 8'd3;
    req_tdata[0] = {8'd0, 8'd0};
    req_tvalid[0] = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_eng_rst", 32'(eng_rst), 32'd1);
    check("abort_req_tready", 32'(req_tready), 32'd0);
    check("abort_eng_tvalid", 32'(eng_tvalid), 32'd0);
    check("abort_eng_m", 32'(eng_m), 32'd0);
    req_tvalid[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    eng_out_tvalid = 1'b1;
    tick();
    eng_out_tvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("abort_no_res", 32'(res_tvalid), 32'd0);
      tick();
    end
    req_m = {8'd1, 8'd1}; req_n = {8'd3, 8'd3};
    req_tdata[1] = {8'd1, 8'd0};
    req_tvalid[1] = 1'b1; req_tlast[1] = 1'b1;
    send_beats(0, 1, seen, last_at, drained);
    respond("tie_after_rst", 8'd2, 0, 1'b0);
    release_res();
    req_tvalid[1] = 1'b0; req_tlast[1] = 1'b0;

`ifdef LC1252_ARB_TIMEOUT_EN
    // Engine silent: result forced after 8 WAIT_RES cycles
    send_beats(0, 1, seen, last_at, drained);
    repeat (7) tick();
    check("tmo_not_yet", 32'(res_tvalid), 32'd0);
    tick();
    check("tmo_vld", 32'(res_tvalid), 32'd1);
    check("tmo_odd", 32'(res_odd_cells), 32'd0);
    check("tmo_err", 32'(res_err), 32'd1);
    check("tmo_id", 32'(res_id), 32'd0);
    release_res();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc_1252_job_arbiter.md
LC_1252_JOB_ARBITER -- requirements
Module: lc_1252_job_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of job requesters (>=2); ID_W = $clog2(NUM_REQ).
REQ-002 SHALL have parameter MAX_IND_LEN, default 100, max index beats per job forwarded to the engine.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, result-wait limit in cycles (used only with the timeout macro).
REQ-004 SHALL have port clk  input  1  single clock; all logic is on posedge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req_m, req_n  input  [NUM_REQ-1:0][7:0]  per-requester matrix dimensions.
REQ-007 SHALL have ports req_tdata [NUM_REQ-1:0][1:0][7:0], req_tvalid/req_tlast [NUM_REQ-1:0] as inputs, and req_tready [NUM_REQ-1:0] as output; together these form the per-requester index stream.
REQ-008 SHALL have ports eng_m, eng_n  output  8 each, and eng_tdata [1:0][7:0], eng_tvalid, eng_tlast as outputs; eng_tready is an input; together these form the stream to the odd-matrix engine.
REQ-009 SHALL have port eng_rst  output  1  active-high synchronous reset to the engine.
REQ-010 SHALL have ports eng_odd_cells  input  8  and eng_out_tvalid  input  1  carrying the engine result.
REQ-011 SHALL have ports res_odd_cells output 8, res_id output ID_W, res_err output 1, res_tvalid output 1, and res_tready input 1; together these form the result channel.

Function
REQ-012 SHALL implement FSM states CLEAN, IDLE, STREAM, DRAIN, WAIT_RES, RESP.
- CLEAN: eng_rst=1 for exactly one cycle, then go to IDLE.
REQ-013 IDLE SHALL grant round-robin among requesters with req_tvalid=1, searching from last_grant+1 mod NUM_REQ.
- On grant: latch the id into grant_id and last_grant, latch req_m/req_n into eng_m/eng_n, clear beat_cnt and err, then go to STREAM.
- With no requester valid, stay in IDLE.
REQ-014 STREAM SHALL combinationally pass the granted requester to the engine:
- eng_tdata = req_tdata[g]; eng_tvalid = req_tvalid[g]; req_tready[g] = eng_tready.
- All other req_tready = 0.
REQ-015 Each handshake (eng_tvalid & eng_tready) SHALL increment beat_cnt.
- eng_tlast = req_tlast[g] | (beat_cnt == MAX_IND_LEN-1).
REQ-016 On a handshake with req_tlast[g]=1, the FSM SHALL go to WAIT_RES.
- On a handshake where beat_cnt == MAX_IND_LEN-1 and req_tlast[g]=0: set err=1 and go to DRAIN.
REQ-017 DRAIN SHALL hold req_tready[g]=1 and eng_tvalid=0, discarding beats, until a req_tlast[g] handshake; then go to WAIT_RES.
REQ-018 WAIT_RES SHALL keep eng_tvalid=0 and all req_tready=0.
- On eng_out_tvalid=1: capture eng_odd_cells into res_odd_cells and go to RESP.
REQ-019 RESP SHALL assert res_tvalid with res_id=grant_id and res_err=err.
- Outputs SHALL be held stable until res_tready=1; the cycle after, go to CLEAN.
REQ-020 Latency: the result SHALL be presented in the cycle after eng_out_tvalid.
REQ-021 A requester that drops tvalid mid-job SHALL keep the grant; the FSM stays in STREAM.
REQ-022 eng_tvalid and req_tready SHALL be 0 in CLEAN, IDLE, WAIT_RES and RESP.

Reset
REQ-023 While rst_n=0, the block SHALL hold:
- state=CLEAN;
- last_grant=NUM_REQ-1, so requester 0 wins the first tie;
- beat_cnt, grant_id, err, res_* = 0; eng_m/eng_n = 0; all req_tready = 0;
- eng_tvalid=0, eng_tlast=0, eng_rst=1.
REQ-024 After rst_n rises, the block SHALL spend one CLEAN cycle (eng_rst=1) before IDLE.
REQ-025 Reset asserted mid-job SHALL abort the job with no result emitted.

Configuration
REQ-026 With macro LC1252_ARB_TIMEOUT_EN defined:
- a 16-bit counter SHALL run in WAIT_RES;
- after TIMEOUT_CYC cycles without eng_out_tvalid, go to RESP with res_odd_cells=0 and res_err=1.
REQ-027 Without LC1252_ARB_TIMEOUT_EN, WAIT_RES SHALL wait indefinitely and no timeout counter SHALL exist.

Verification
REQ-028 Requester 0: m=2, n=3, beats (0,1),(1,1) with tlast on beat 2 -> res_odd_cells=6, res_id=0, res_err=0; then eng_rst pulses for 1 cycle.
REQ-029 Requester 1: m=2, n=2, beats (1,1),(0,0) -> res_odd_cells=0, res_id=1, res_err=0.
REQ-030 Both requesters valid right after reset -> requester 0 is served first, then requester 1, with no idle job overlap; a second tie is then won by requester 0 again (rotation verified).
REQ-031 MAX_IND_LEN=4, requester sends 6 beats -> engine sees 4 beats with tlast on beat 4; beats 5-6 are drained; res_err=1.
REQ-032 res_tready held 0 for 5 cycles -> res_* held stable; no new grant until the handshake.
REQ-033 With LC1252_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, engine never responds -> res_tvalid=1, res_odd_cells=0, res_err=1 after 8 WAIT_RES cycles.
